// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module   : mem_access_sequencer
// Brief    : Multi-cycle sequencer for byte/half/word loads and stores against
//            a word-wide synchronous-read data memory (lane extract / RMW).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_access_sequencer #(
    parameter int READ_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Stall,
    output logic        Done,
    output logic        Misaligned,
    output logic [31:0] RdData,
    output logic [31:0] MemAddr,
    output logic        MemRdEn,
    output logic        MemWrEn,
    output logic [31:0] MemWrWord,
    input  logic [31:0] MemRdWord
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [2:0]  cnt;
    logic [2:0]  cnt_inc;
    logic        last_wait;
    logic        accept;
    logic        mis_acc;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        store_q;
    logic        err_q;
    logic [31:0] word_q;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Lane select + sign/zero extension; little-endian lane numbering.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        zext,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        if (size[1])
            r = word;
        else if (size[0])
            r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
        else
            r = zext ? {24'h000000, b} : {{24{b[7]}}, b};
        return r;
    endfunction

    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = word;
        if (size[1])
            r = data;
        else if (size[0])
            r[{off[1], 4'b0000} +: 16] = data[15:0];
        else
            r[{off, 3'b000} +: 8] = data[7:0];
        return r;
    endfunction

    assign accept    = (state == S_IDLE) && Start && (MemRead || MemWrite);
    assign mis_acc   = ((Size == 2'b01) && Addr[0]) || (Size[1] && (Addr[1:0] != 2'b00));
    assign cnt_inc   = cnt + 3'd1;
    assign last_wait = (cnt_inc == LAT);
    assign load_val  = load_extend(MemRdWord, size_q, unsigned_q, addr_q[1:0]);
    assign merged    = store_merge(word_q, wdata_q, size_q, addr_q[1:0]);
    assign MemAddr   = {addr_q[31:2], 2'b00};

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (mis_acc)
                        next_state = S_DONE;
                    else if (MemWrite && Size[1])
                        next_state = S_WR;
                    else
                        next_state = S_RD;
                end
            end
            S_RD:   next_state = S_WAIT;
            S_WAIT: begin
                if (last_wait)
                    next_state = store_q ? S_WR : S_DONE;
            end
            S_WR:   next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs: enables and pulses come from the state register only
    always_comb begin
        MemRdEn    = (state == S_RD);
        MemWrEn    = (state == S_WR);
        Done       = (state == S_DONE);
        Misaligned = (state == S_DONE) && err_q;
        Stall      = accept || (state == S_RD) || (state == S_WAIT) || (state == S_WR);
        MemWrWord  = (state == S_WR) ? merged : 32'h0000_0000;
    end

    // Request capture, wait counter and read data path
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= 3'd0;
            word_q     <= 32'h0000_0000;
            RdData     <= 32'h0000_0000;
        end else begin
            if (accept) begin
                addr_q     <= Addr;
                wdata_q    <= WrData;
                size_q     <= Size;
                unsigned_q <= Unsigned;
                store_q    <= MemWrite;
                err_q      <= mis_acc;
            end
            if (state == S_RD)
                cnt <= 3'd0;
            else if (state == S_WAIT)
                cnt <= cnt_inc;
            if ((state == S_WAIT) && last_wait) begin
                word_q <= MemRdWord;
                if (!store_q)
                    RdData <= load_val;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// Module   : tb_mem_access_sequencer
// Brief    : Table-driven bench with scoreboard for mem_access_sequencer,
//            driving a READ_LATENCY=1 and a READ_LATENCY=3 instance together.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_sequencer;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_init;
        logic [31:0] exp_rd;
        logic [31:0] exp_word;
        logic        exp_mis;
        logic        pulse;
    } vec_t;

    typedef struct {
        logic        mis;
        logic        is_load;
        int          done_cyc;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] WrData;

    logic        stall [2];
    logic        done  [2];
    logic        mis   [2];
    logic        rden  [2];
    logic        wren  [2];
    logic [31:0] rdata [2];
    logic [31:0] maddr [2];
    logic [31:0] wword [2];
    logic [31:0] rword [2];

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;

    int checks = 0;
    int errors = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    vec_t vecs [17];

    always #5 Clk = ~Clk;

    mem_access_sequencer #(.READ_LATENCY(1)) dut_l1 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WrData(WrData),
        .Stall(stall[0]), .Done(done[0]), .Misaligned(mis[0]), .RdData(rdata[0]),
        .MemAddr(maddr[0]), .MemRdEn(rden[0]), .MemWrEn(wren[0]),
        .MemWrWord(wword[0]), .MemRdWord(rword[0])
    );

    mem_access_sequencer #(.READ_LATENCY(3)) dut_l3 (
        .Clk(Clk), .Rst(Rst), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
        .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WrData(WrData),
        .Stall(stall[1]), .Done(done[1]), .Misaligned(mis[1]), .RdData(rdata[1]),
        .MemAddr(maddr[1]), .MemRdEn(rden[1]), .MemWrEn(wren[1]),
        .MemWrWord(wword[1]), .MemRdWord(rword[1])
    );

    // Synchronous-read memories; junk is shifted in when no read is enabled
    always @(posedge Clk) begin
        if (pl_en) begin
            mem0[pl_idx] <= pl_val;
            mem1[pl_idx] <= pl_val;
        end
        if (wren[0]) mem0[maddr[0][7:2]] <= wword[0];
        if (wren[1]) mem1[maddr[1][7:2]] <= wword[1];
        pipe0    <= rden[0] ? mem0[maddr[0][7:2]] : 32'hBAD0_BAD0;
        pipe1[0] <= rden[1] ? mem1[maddr[1][7:2]] : 32'hBAD1_BAD1;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rword[0] = pipe0;
    assign rword[1] = pipe1[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mem_init, input logic [31:0] exp_rd,
                                input logic [31:0] exp_word, input logic exp_mis, input logic pulse);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.mem_init = mem_init; v.exp_rd = exp_rd; v.exp_word = exp_word;
        v.exp_mis = exp_mis; v.pulse = pulse;
        return v;
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(posedge Clk); #1;
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge Clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        exp_t e;
        exp_t cur [2];
        int   rd_first [2], rd_cnt [2], wr_first [2], wr_cnt [2], done_cnt [2], stall_cnt [2];
        logic [31:0] rd_a [2], wr_a [2], wr_w [2];
        bit   popped [2];
        string tag;
        preload(v.addr[7:2], v.mem_init);
        for (int d = 0; d < 2; d++) begin
            int lat;
            lat = (d == 0) ? 1 : 3;
            e.mis = v.exp_mis;
            e.is_load = !v.wr;
            if (v.exp_mis) begin
                e.done_cyc = 1; e.rd_cyc = -1; e.wr_cyc = -1;
            end else if (v.wr && v.size[1]) begin
                e.done_cyc = 2; e.rd_cyc = -1; e.wr_cyc = 1;
            end else if (v.wr) begin
                e.done_cyc = 3 + lat; e.rd_cyc = 1; e.wr_cyc = 2 + lat;
            end else begin
                e.done_cyc = 2 + lat; e.rd_cyc = 1; e.wr_cyc = -1;
            end
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
            rd_first[d] = -1; wr_first[d] = -1; rd_cnt[d] = 0; wr_cnt[d] = 0;
            done_cnt[d] = 0; stall_cnt[d] = 0; popped[d] = 1'b0;
            rd_a[d] = 32'h0; wr_a[d] = 32'h0; wr_w[d] = 32'h0;
        end
        @(posedge Clk); #1;
        Start = 1'b1; MemRead = v.rd; MemWrite = v.wr; Size = v.size;
        Unsigned = v.uns; Addr = v.addr; WrData = v.wdata;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                tag = $sformatf("v%0d_l%0d", vi, (d == 0) ? 1 : 3);
                if (stall[d]) stall_cnt[d]++;
                if (rden[d]) begin
                    if (rd_cnt[d] == 0) begin rd_first[d] = c; rd_a[d] = maddr[d]; end
                    rd_cnt[d]++;
                end
                if (wren[d]) begin
                    if (wr_cnt[d] == 0) begin wr_first[d] = c; wr_a[d] = maddr[d]; wr_w[d] = wword[d]; end
                    wr_cnt[d]++;
                end
                if (done[d]) begin
                    done_cnt[d]++;
                    if (!popped[d]) begin
                        popped[d] = 1'b1;
                        if (d == 0) cur[d] = sb0.pop_front(); else cur[d] = sb1.pop_front();
                        chk({tag, "_done_cycle"}, c, cur[d].done_cyc);
                        chk({tag, "_misaligned"}, {31'h0, mis[d]}, {31'h0, cur[d].mis});
                        chk({tag, "_rden_cycle"}, rd_first[d], cur[d].rd_cyc);
                        chk({tag, "_rden_count"}, rd_cnt[d], (cur[d].rd_cyc < 0) ? 0 : 1);
                        chk({tag, "_wren_cycle"}, wr_first[d], cur[d].wr_cyc);
                        chk({tag, "_wren_count"}, wr_cnt[d], (cur[d].wr_cyc < 0) ? 0 : 1);
                        if (cur[d].rd_cyc >= 0)
                            chk({tag, "_rd_addr"}, rd_a[d], {v.addr[31:2], 2'b00});
                        if (cur[d].wr_cyc >= 0) begin
                            chk({tag, "_wr_addr"}, wr_a[d], {v.addr[31:2], 2'b00});
                            chk({tag, "_wr_word"}, wr_w[d], v.exp_word);
                        end
                        if (cur[d].is_load && !cur[d].mis)
                            chk({tag, "_rddata"}, rdata[d], v.exp_rd);
                    end
                end
            end
            @(posedge Clk); #1;
            if (c == 0) Start = v.pulse;
            else if (c == 1) Start = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            tag = $sformatf("v%0d_l%0d", vi, (d == 0) ? 1 : 3);
            if (!popped[d]) begin
                chk({tag, "_done_seen"}, 32'd0, 32'd1);
                if (d == 0) cur[d] = sb0.pop_front(); else cur[d] = sb1.pop_front();
            end
            chk({tag, "_done_count"}, done_cnt[d], 1);
            chk({tag, "_stall_cycles"}, stall_cnt[d], cur[d].done_cyc);
        end
    endtask

    initial begin
        Rst = 1'b0; Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00;
        Unsigned = 1'b0; Addr = 32'h0; WrData = 32'h0;
        //          rd wr size  uns addr         wdata         mem           exp_rd        exp_word      mis pulse
        vecs[0]  = mk(1, 0, 2'b00, 0, 32'h13, 32'h0,        32'h80FF_1234, 32'hFFFF_FF80, 32'h0,        0, 0);
        vecs[1]  = mk(1, 0, 2'b00, 1, 32'h13, 32'h0,        32'h80FF_1234, 32'h0000_0080, 32'h0,        0, 0);
        vecs[2]  = mk(0, 1, 2'b00, 0, 32'h21, 32'h0000_00AB, 32'h1122_3344, 32'h0,        32'h1122_AB44, 0, 0);
        vecs[3]  = mk(0, 1, 2'b01, 0, 32'h02, 32'h0000_BEEF, 32'h1122_3344, 32'h0,        32'hBEEF_3344, 0, 0);
        vecs[4]  = mk(1, 0, 2'b10, 0, 32'h06, 32'h0,        32'h0,         32'h0,         32'h0,        1, 0);
        vecs[5]  = mk(0, 1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 32'h0,        32'h0,         32'hDEAD_BEEF, 0, 1);
        vecs[6]  = mk(1, 0, 2'b01, 0, 32'h02, 32'h0,        32'h8001_7FFF, 32'hFFFF_8001, 32'h0,        0, 0);
        vecs[7]  = mk(1, 0, 2'b01, 1, 32'h02, 32'h0,        32'h8001_7FFF, 32'h0000_8001, 32'h0,        0, 0);
        vecs[8]  = mk(1, 0, 2'b01, 0, 32'h00, 32'h0,        32'h8001_7FFF, 32'h0000_7FFF, 32'h0,        0, 0);
        vecs[9]  = mk(1, 0, 2'b00, 0, 32'h05, 32'h0,        32'h1234_5678, 32'h0000_0056, 32'h0,        0, 0);
        vecs[10] = mk(0, 1, 2'b01, 0, 32'h05, 32'h0000_1234, 32'h0,        32'h0,         32'h0,        1, 0);
        vecs[11] = mk(0, 1, 2'b00, 0, 32'h03, 32'hFFFF_FF77, 32'hAABB_CCDD, 32'h0,        32'h77BB_CCDD, 0, 0);
        vecs[12] = mk(1, 0, 2'b10, 0, 32'h0C, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0,        0, 0);
        vecs[13] = mk(1, 0, 2'b11, 1, 32'h10, 32'h0,        32'h0102_0304, 32'h0102_0304, 32'h0,        0, 0);
        vecs[14] = mk(1, 1, 2'b10, 0, 32'h14, 32'h55AA_55AA, 32'h0,        32'h0,         32'h55AA_55AA, 0, 0);
        vecs[15] = mk(1, 1, 2'b00, 0, 32'h02, 32'h0000_00CC, 32'h0,        32'h0,         32'h00CC_0000, 0, 0);
        vecs[16] = mk(1, 0, 2'b11, 0, 32'h01, 32'h0,        32'h0,         32'h0,         32'h0,        1, 0);

        #1 Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_l%0d_stall", d), {31'h0, stall[d]}, 32'h0);
            chk($sformatf("reset_l%0d_done", d), {31'h0, done[d]}, 32'h0);
            chk($sformatf("reset_l%0d_mis", d), {31'h0, mis[d]}, 32'h0);
            chk($sformatf("reset_l%0d_rden", d), {31'h0, rden[d]}, 32'h0);
            chk($sformatf("reset_l%0d_wren", d), {31'h0, wren[d]}, 32'h0);
            chk($sformatf("reset_l%0d_wrword", d), wword[d], 32'h0);
            chk($sformatf("reset_l%0d_memaddr", d), maddr[d], 32'h0);
            chk($sformatf("reset_l%0d_rddata", d), rdata[d], 32'h0);
        end
        @(posedge Clk); #1 Rst = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Start without a read or write request must be ignored
        @(posedge Clk); #1;
        Start = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge Clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("noop_l%0d_stall", d), {31'h0, stall[d]}, 32'h0);
        @(posedge Clk); #1 Start = 1'b0;
        begin
            int busy;
            busy = 0;
            repeat (4) begin
                @(negedge Clk);
                for (int d = 0; d < 2; d++) if (stall[d] || done[d] || rden[d] || wren[d]) busy++;
            end
            chk("noop_activity", busy, 0);
        end

        // Asynchronous reset while in WR
        preload(6'd2, 32'h1111_2222);
        @(posedge Clk); #1;
        Start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'b10; Addr = 32'h08; WrData = 32'hDEAD_BEEF;
        @(posedge Clk); #1 Start = 1'b0;
        @(negedge Clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("arst_l%0d_wren_before", d), {31'h0, wren[d]}, 32'h1);
        #1 Rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("arst_l%0d_wren", d), {31'h0, wren[d]}, 32'h0);
            chk($sformatf("arst_l%0d_stall", d), {31'h0, stall[d]}, 32'h0);
            chk($sformatf("arst_l%0d_done", d), {31'h0, done[d]}, 32'h0);
        end
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("arst_mem_l1_untouched", mem0[2], 32'h1111_2222);
        chk("arst_mem_l3_untouched", mem1[2], 32'h1111_2222);
        run_vec(100, vecs[12]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
